if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS core.
- Owns the PC register and drives the word-aligned address into the combinational instruction ROM, which returns data in the same cycle.
- Captures the returned word into the IF/ID pipeline register.
- Next-PC selection arbitrates reset, exception entry, EX-stage branch redirect, ID-stage jump redirect, stall, and sequential PC+4.

---
 rtl/if_pkg.sv | 26 ++
 rtl/if_next_pc_sel.sv | 63 ++++++
 rtl/if_fetch_stage.sv | 83 ++++++++
 tb/tb_if_fetch_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and next-PC select type for the fetch stage
package if_pkg;

  localparam logic [5:0]  OP_J           = 6'b000010;
  localparam logic [5:0]  OP_JAL         = 6'b000011;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0008;
  localparam logic [31:0] DEF_NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_EXC,
    SEL_EX,
    SEL_ID,
    SEL_HOLD,
    SEL_JUMP,
    SEL_SEQ
  } next_pc_sel_e;

  // Redirect targets may arrive misaligned; the PC must stay on a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_next_pc_sel.sv
// rtl/if_next_pc_sel.sv - combinational next-PC priority mux
// IF_EARLY_JUMP_EN adds J/JAL pre-decode of the fetched word.
module if_next_pc_sel
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic         reset,
  input  logic         exc_req,
  input  logic         ex_redirect,
  input  logic [31:0]  ex_target,
  input  logic         id_redirect,
  input  logic [31:0]  id_target,
  input  logic         stall,
  input  logic [31:0]  pc_plus4,
  input  logic [31:0]  rom_data,
  output next_pc_sel_e sel,
  output logic [31:0]  next_pc,
  output logic         bubble
);

  logic jump_hit;

`ifdef IF_EARLY_JUMP_EN
  assign jump_hit = (rom_data[31:26] == OP_J) || (rom_data[31:26] == OP_JAL);
`else
  logic unused_rom_data;
  assign unused_rom_data = ^rom_data;
  assign jump_hit        = 1'b0;
`endif

  // Redirects deliberately outrank stall so a wrong-path word is never held.
  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc_plus4;
    bubble  = 1'b0;
    if (reset) begin
      sel     = SEL_RESET;
      next_pc = RESET_PC;
      bubble  = 1'b1;
    end else if (exc_req) begin
      sel     = SEL_EXC;
      next_pc = EXC_VECTOR;
      bubble  = 1'b1;
    end else if (ex_redirect) begin
      sel     = SEL_EX;
      next_pc = word_align(ex_target);
      bubble  = 1'b1;
    end else if (id_redirect) begin
      sel     = SEL_ID;
      next_pc = word_align(id_target);
      bubble  = 1'b1;
    end else if (stall) begin
      sel     = SEL_HOLD;
      next_pc = pc_plus4 - 32'd4;
    end else if (jump_hit) begin
      sel     = SEL_JUMP;
      next_pc = {pc_plus4[31:28], rom_data[25:0], 2'b00};
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: PC register and IF/ID pipeline register
// Define IF_EARLY_JUMP_EN to resolve J/JAL in fetch instead of ID.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [31:0] NOP_INSTR  = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] pc_out
);

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         bubble;
  next_pc_sel_e sel;

  assign rom_addr = pc;
  assign pc_out   = pc;
  assign pc_plus4 = pc + 32'd4;

  if_next_pc_sel #(
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc_sel (
    .reset       (reset),
    .exc_req     (exc_req),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .id_redirect (id_redirect),
    .id_target   (id_target),
    .stall       (stall),
    .pc_plus4    (pc_plus4),
    .rom_data    (rom_data),
    .sel         (sel),
    .next_pc     (next_pc),
    .bubble      (bubble)
  );

  always_ff @(posedge clk) begin
    case (sel)
      SEL_RESET: begin
        pc            <= RESET_PC;
        ifid_instr    <= NOP_INSTR;
        ifid_pc_plus4 <= 32'h0;
        ifid_valid    <= 1'b0;
      end
      SEL_HOLD: begin
        pc            <= pc;
        ifid_instr    <= ifid_instr;
        ifid_pc_plus4 <= ifid_pc_plus4;
        ifid_valid    <= ifid_valid;
      end
      default: begin
        pc            <= next_pc;
        ifid_pc_plus4 <= pc_plus4;
        // An early-resolved jump still enters IF/ID so JAL can link.
        if (bubble) begin
          ifid_instr <= NOP_INSTR;
          ifid_valid <= 1'b0;
        end else begin
          ifid_instr <= rom_data;
          ifid_valid <= 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed and random checks of if_fetch_stage against a reference model
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        exc_req;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        id_redirect;
  logic [31:0] id_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] pc_out;

  logic [31:0] rom [64];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr[7:2]];

  if_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .stall         (stall),
    .exc_req       (exc_req),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .id_redirect   (id_redirect),
    .id_target     (id_target),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .pc_out        (pc_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what one clock does to the architectural fetch state.
  task automatic model_clock();
    logic [31:0] word;
    logic [31:0] seq;
    word = rom[m_pc[7:2]];
    seq  = m_pc + 32'd4;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (exc_req || ex_redirect || id_redirect) begin
      m_instr = 32'h0; m_valid = 1'b0; m_pp4 = seq;
      if (exc_req)          m_pc = 32'h8;
      else if (ex_redirect) m_pc = {ex_target[31:2], 2'b00};
      else                  m_pc = {id_target[31:2], 2'b00};
    end else if (!stall) begin
      m_instr = word; m_valid = 1'b1; m_pp4 = seq;
      m_pc = seq;
`ifdef IF_EARLY_JUMP_EN
      if (word[31:27] == 5'b00001) m_pc = {seq[31:28], word[25:0], 2'b00};
`endif
    end
  endtask

  task automatic step(input string name);
    model_clock();
    @(posedge clk);
    #1;
    check($sformatf("%s.rom_addr", name), rom_addr, m_pc);
    check($sformatf("%s.pc_out", name), pc_out, m_pc);
    check($sformatf("%s.ifid_instr", name), ifid_instr, m_instr);
    check($sformatf("%s.ifid_pc_plus4", name), ifid_pc_plus4, m_pp4);
    check($sformatf("%s.ifid_valid", name), {31'h0, ifid_valid}, {31'h0, m_valid});
  endtask

  task automatic clear_ctl();
    stall = 1'b0; exc_req = 1'b0; ex_redirect = 1'b0; id_redirect = 1'b0;
    ex_target = 32'h0; id_target = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    clear_ctl();
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h2000_0000 | i;

    step("rst0");
    step("rst1");
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);

    reset = 1'b0;
    #1;
    check("release_rom_addr", rom_addr, 32'h0);
    step("seq0");
    check("seq0_pp4", ifid_pc_plus4, 32'h4);
    check("seq0_instr", ifid_instr, 32'h2000_0000);
    step("seq1");
    check("seq1_rom_addr", rom_addr, 32'h8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall_rom_addr", rom_addr, 32'h8);
    check("stall_pp4", ifid_pc_plus4, 32'h8);
    stall = 1'b0;
    step("unstall");
    check("unstall_rom_addr", rom_addr, 32'hC);

    ex_redirect = 1'b1; ex_target = 32'h28;
    id_redirect = 1'b1; id_target = 32'h40; stall = 1'b1;
    step("ex_over_id");
    check("ex_over_id_rom_addr", rom_addr, 32'h28);
    check("ex_over_id_valid", {31'h0, ifid_valid}, 32'h0);
    check("ex_over_id_instr", ifid_instr, 32'h0);
    clear_ctl();
    step("after_ex");

    exc_req = 1'b1; ex_redirect = 1'b1; ex_target = 32'h100;
    step("exc_over_ex");
    check("exc_rom_addr", rom_addr, 32'h8);
    check("exc_valid", {31'h0, ifid_valid}, 32'h0);
    clear_ctl();

    rom[4] = 32'h0810_0000;
    step("to_c");
    step("to_10");
    step("jump");
`ifdef IF_EARLY_JUMP_EN
    check("jump_rom_addr", rom_addr, 32'h0040_0000);
`else
    check("jump_rom_addr", rom_addr, 32'h14);
`endif
    check("jump_instr", ifid_instr, 32'h0810_0000);
    check("jump_valid", {31'h0, ifid_valid}, 32'h1);
    check("jump_pp4", ifid_pc_plus4, 32'h14);

    ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFC;
    step("preload_top");
    clear_ctl();
    step("wrap");
    check("wrap_rom_addr", rom_addr, 32'h0);
    check("wrap_pp4", ifid_pc_plus4, 32'h0);
    ex_redirect = 1'b1; ex_target = 32'h23;
    step("misaligned");
    check("misaligned_rom_addr", rom_addr, 32'h20);
    clear_ctl();
    step("post_align");

    reset = 1'b1; stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h80;
    step("reset_override");
    check("reset_override_rom_addr", rom_addr, 32'h0);
    check("reset_override_pp4", ifid_pc_plus4, 32'h0);
    reset = 1'b0;
    clear_ctl();

    for (int i = 0; i < 64; i++) begin
      rom[i] = $urandom;
      if ($urandom_range(0, 5) == 0) rom[i][31:26] = ($urandom_range(0, 1) == 0) ? 6'b000010 : 6'b000011;
    end
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 39) == 0);
      exc_req     = ($urandom_range(0, 24) == 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      id_redirect = ($urandom_range(0, 7) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      ex_target   = $urandom;
      id_target   = $urandom;
      step($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
